hyperbola_sqrt_sched: RTL and testbench

HYPERBOLA_SQRT_SCHED -- requirements
Module: hyperbola_sqrt_sched

---
 rtl/sqrt_pkg.sv | 29 ++
 rtl/hyperbola_sqrt_sched_delay.sv | 36 +++
 rtl/hyperbola_sqrt_sched.sv | 151 +++++++++++++++
 tb/tb_hyperbola_sqrt_sched.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared constants and FSM encoding for the hyperbolic square-root scheduler.
// Fixed point is Q1.(DSIZE-1): 1.0 is 2**(DSIZE-1).
package sqrt_pkg;

    localparam int unsigned DSIZE_DEF     = 17;
    localparam int unsigned STAGE_LAT_DEF = 5;
    localparam int unsigned ROT_START_DEF = 1;
    localparam int unsigned ROT_MAX_DEF   = 16;

    localparam int unsigned ROT_W  = 6;
    localparam int unsigned PASS_W = 5;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    function automatic int unsigned one_q_of(input int unsigned dsize);
        return 32'd1 << (dsize - 1);
    endfunction

    function automatic int unsigned quarter_q_of(input int unsigned dsize);
        return one_q_of(dsize) >> 2;
    endfunction

    localparam int unsigned ONE_Q     = one_q_of(DSIZE_DEF);
    localparam int unsigned QUARTER_Q = quarter_q_of(DSIZE_DEF);

endpackage

// File: rtl/hyperbola_sqrt_sched_delay.sv
// Fixed-latency delay line: din appears on dout LAT clock edges later.
module hyperbola_sqrt_sched_delay #(
    parameter int unsigned LAT   = 5,
    parameter int unsigned DSIZE = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] din,
    output logic [DSIZE-1:0] dout
);

    logic [DSIZE-1:0] pipe_q [LAT];
    logic [DSIZE-1:0] pipe_d [LAT];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[LAT-1];

endmodule

// File: rtl/hyperbola_sqrt_sched.sv
// Pass scheduler for an external radix-4 hyperbolic stage computing sqrt(a):
// issues x=a+0.25, y=a-0.25 and recirculates the stage result until the rotation index ends.
module hyperbola_sqrt_sched
    import sqrt_pkg::*;
#(
    parameter int unsigned DSIZE     = DSIZE_DEF,
    parameter int unsigned STAGE_LAT = STAGE_LAT_DEF,
    parameter int unsigned ROT_START = ROT_START_DEF,
    parameter int unsigned ROT_MAX   = ROT_MAX_DEF
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DSIZE-1:0]        in_a,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DSIZE-1:0]        res_x,
    output logic [DSIZE-1:0]        res_k,
    output logic [PASS_W-1:0]       res_passes,
    output logic [DSIZE-1:0]        stg_ix,
    output logic signed [DSIZE-1:0] stg_iy,
    output logic [ROT_W-1:0]        stg_rot,
    output logic [DSIZE-1:0]        stg_k,
    input  logic [DSIZE-1:0]        stg_ox,
    input  logic signed [DSIZE-1:0] stg_oy,
    input  logic [ROT_W-1:0]        stg_nrot,
    input  logic [DSIZE-1:0]        stg_nk
);

    localparam logic [DSIZE-1:0] OneQ     = DSIZE'(one_q_of(DSIZE));
    localparam logic [DSIZE-1:0] QuarterQ = DSIZE'(quarter_q_of(DSIZE));
    localparam logic [ROT_W-1:0] RotStart = ROT_W'(ROT_START);
    localparam logic [ROT_W-1:0] RotMax   = ROT_W'(ROT_MAX);
    localparam int unsigned      CW       = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
    localparam logic [CW-1:0]    WaitLast = CW'(STAGE_LAT - 1);

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [DSIZE-1:0]        stg_ix_q, stg_ix_d;
    logic signed [DSIZE-1:0] stg_iy_q, stg_iy_d;
    logic [ROT_W-1:0]        stg_rot_q, stg_rot_d;
    logic [DSIZE-1:0]        stg_k_q, stg_k_d;
    logic [PASS_W-1:0]       passes_q, passes_d;

    logic accept;
    logic load;
    logic issue_pulse;
    logic issue_due;

    assign in_ready    = !rst && ((state_q == StIdle) || ((state_q == StDone) && res_ready));
    assign accept      = in_valid && in_ready;
    assign issue_pulse = (state_q == StIssue);

    // Tracks the issue pulse through the stage latency; capture needs both it and the counter.
    hyperbola_sqrt_sched_delay #(
        .LAT   (STAGE_LAT),
        .DSIZE (1)
    ) u_issue_delay (
        .clock (clock),
        .rst_n (1'b1),
        .din   (issue_pulse),
        .dout  (issue_due)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stg_ix_d   = stg_ix_q;
        stg_iy_d   = stg_iy_q;
        stg_rot_d  = stg_rot_q;
        stg_k_d    = stg_k_q;
        passes_d   = passes_q;
        load       = 1'b0;

        case (state_q)
            StIdle: begin
                load = accept;
            end
            StIssue: begin
                state_d    = StWait;
                wait_cnt_d = '0;
            end
            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    if (issue_due) begin
                        stg_ix_d  = stg_ox;
                        stg_iy_d  = stg_oy;
                        stg_rot_d = stg_nrot;
                        stg_k_d   = stg_nk;
                        passes_d  = passes_q + PASS_W'(1);
                        state_d   = (stg_nrot >= RotMax) ? StDone : StIssue;
                    end else begin
                        // Counter and delay line disagree: re-issue the unchanged operands.
                        state_d = StIssue;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                    load    = accept;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            stg_ix_d  = in_a + QuarterQ;
            stg_iy_d  = $signed(in_a - QuarterQ);
            stg_rot_d = RotStart;
            stg_k_d   = OneQ;
            passes_d  = '0;
            state_d   = StIssue;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            stg_ix_q   <= '0;
            stg_iy_q   <= '0;
            stg_rot_q  <= '0;
            stg_k_q    <= '0;
            passes_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stg_ix_q   <= stg_ix_d;
            stg_iy_q   <= stg_iy_d;
            stg_rot_q  <= stg_rot_d;
            stg_k_q    <= stg_k_d;
            passes_q   <= passes_d;
        end
    end

    assign stg_ix     = stg_ix_q;
    assign stg_iy     = stg_iy_q;
    assign stg_rot    = stg_rot_q;
    assign stg_k      = stg_k_q;
    assign res_valid  = (state_q == StDone);
    assign res_x      = stg_ix_q;
    assign res_k      = stg_k_q;
    assign res_passes = passes_q;

endmodule

// File: tb/tb_hyperbola_sqrt_sched.sv
// Directed bench for hyperbola_sqrt_sched with a behavioural radix-4 hyperbolic stage.
module tb_hyperbola_sqrt_sched;

    localparam int DW  = 17;
    localparam int LAT = 5;

    logic                 clock = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 res_ready = 1'b0;
    logic [DW-1:0]        in_a = '0;
    logic                 in_ready;
    logic                 res_valid;
    logic [DW-1:0]        res_x;
    logic [DW-1:0]        res_k;
    logic [4:0]           res_passes;
    logic [DW-1:0]        stg_ix;
    logic signed [DW-1:0] stg_iy;
    logic [5:0]           stg_rot;
    logic [DW-1:0]        stg_k;
    logic [DW-1:0]        stg_ox;
    logic signed [DW-1:0] stg_oy;
    logic [5:0]           stg_nrot;
    logic [DW-1:0]        stg_nk;

    int n_cmp = 0;
    int n_bad = 0;

    hyperbola_sqrt_sched #(
        .DSIZE     (DW),
        .STAGE_LAT (LAT),
        .ROT_START (1),
        .ROT_MAX   (16)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_x      (res_x),
        .res_k      (res_k),
        .res_passes (res_passes),
        .stg_ix     (stg_ix),
        .stg_iy     (stg_iy),
        .stg_rot    (stg_rot),
        .stg_k      (stg_k),
        .stg_ox     (stg_ox),
        .stg_oy     (stg_oy),
        .stg_nrot   (stg_nrot),
        .stg_nk     (stg_nk)
    );

    always #5 clock = ~clock;

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // Stage: y==0 skips four rotations; otherwise iterations rot and rot+1 (4 and 13 repeated).
    function automatic void stage_fn(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                     input logic [5:0] rot, input logic [DW-1:0] k,
                                     output logic [DW-1:0] ox, output logic [DW-1:0] oy,
                                     output logic [5:0] nrot, output logic [DW-1:0] nk);
        real xr, yr, kr, t, xn;
        int  i;
        if (y == '0) begin
            ox   = x;
            oy   = y;
            nrot = rot + 6'd4;
            nk   = k;
            return;
        end
        xr = real'(int'(x)) / 65536.0;
        yr = real'(int'($signed(y))) / 65536.0;
        kr = real'(int'(k)) / 65536.0;
        for (int j = 0; j < 2; j++) begin
            i = int'(rot) + j;
            for (int r = 0; r < (((i == 4) || (i == 13)) ? 2 : 1); r++) begin
                t = 1.0;
                for (int s = 0; s < i; s++) t = t / 2.0;
                if (yr >= 0.0) begin
                    xn = xr - yr * t;
                    yr = yr - xr * t;
                end else begin
                    xn = xr + yr * t;
                    yr = yr + xr * t;
                end
                xr = xn;
                kr = kr * $sqrt(1.0 - t * t);
            end
        end
        ox   = DW'(rnd(xr * 65536.0));
        oy   = DW'(rnd(yr * 65536.0));
        nk   = DW'(rnd(kr * 65536.0));
        nrot = rot + 6'd2;
    endfunction

    logic [DW-1:0] s_x, s_y, s_k;
    logic [5:0]    s_r;
    logic [DW-1:0] px [LAT];
    logic [DW-1:0] py [LAT];
    logic [DW-1:0] pk [LAT];
    logic [5:0]    pr [LAT];

    always_comb stage_fn(stg_ix, stg_iy, stg_rot, stg_k, s_x, s_y, s_r, s_k);

    always @(posedge clock) begin
        px[0] <= s_x;
        py[0] <= s_y;
        pr[0] <= s_r;
        pk[0] <= s_k;
        for (int i = 1; i < LAT; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            pr[i] <= pr[i-1];
            pk[i] <= pk[i-1];
        end
    end

    assign stg_ox   = px[LAT-1];
    assign stg_oy   = py[LAT-1];
    assign stg_nrot = pr[LAT-1];
    assign stg_nk   = pk[LAT-1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_to_done(input int c0, output int cyc);
        cyc = c0;
        while (res_valid !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        if (res_valid !== 1'b1) cyc = -1;
    endtask

    task automatic model_run(input logic [DW-1:0] a, output logic [DW-1:0] ex,
                             output logic [DW-1:0] ek, output int np);
        logic [DW-1:0] x, y, k, ox, oy, nk;
        logic [5:0]    r, nr;
        x  = a + 17'h04000;
        y  = a - 17'h04000;
        r  = 6'd1;
        k  = 17'h10000;
        np = 0;
        do begin
            stage_fn(x, y, r, k, ox, oy, nr, nk);
            x = ox;
            y = oy;
            r = nr;
            k = nk;
            np++;
        end while (r < 6'd16 && np < 32);
        ex = x;
        ek = k;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %0b want 0", in_ready);
        end
        n_cmp++;
        if (res_valid !== 1'b0 || res_x !== '0 || res_k !== '0 || res_passes !== '0) begin
            n_bad++;
            $display("FAIL reset_res: got v=%0b x=%h k=%h p=%0d want all 0",
                     res_valid, res_x, res_k, res_passes);
        end
        n_cmp++;
        if (stg_ix !== '0 || stg_iy !== '0 || stg_rot !== '0 || stg_k !== '0) begin
            n_bad++;
            $display("FAIL reset_stg: got ix=%h iy=%h rot=%0d k=%h want all 0",
                     stg_ix, stg_iy, stg_rot, stg_k);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_first_pass();
        int cyc;
        in_a = 17'h04000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (stg_ix !== 17'h08000 || stg_iy !== 17'sh0 || stg_rot !== 6'd1 || stg_k !== 17'h10000)
        begin
            n_bad++;
            $display("FAIL issue_vals: got ix=%h iy=%h rot=%0d k=%h want 08000 0 1 10000",
                     stg_ix, stg_iy, stg_rot, stg_k);
        end
        repeat (6) tick();
        n_cmp++;
        if (stg_rot !== 6'd5 || stg_ix !== 17'h08000 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL first_capture: got rot=%0d ix=%h v=%0b want 5 08000 0",
                     stg_rot, stg_ix, res_valid);
        end
        run_to_done(6, cyc);
        n_cmp++;
        if (cyc !== 24) begin
            n_bad++;
            $display("FAIL quarter_latency: got %0d want 24", cyc);
        end
        n_cmp++;
        if (res_x !== 17'h08000 || res_k !== 17'h10000 || res_passes !== 5'd4) begin
            n_bad++;
            $display("FAIL quarter_result: got x=%h k=%h p=%0d want 08000 10000 4",
                     res_x, res_k, res_passes);
        end
        release_result();
        n_cmp++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL quarter_release: got v=%0b rdy=%0b want 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_model(output logic [DW-1:0] ex, output logic [DW-1:0] ek,
                              output int np);
        int  cyc;
        real err;
        model_run(17'h09000, ex, ek, np);
        in_a = 17'h09000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_to_done(0, cyc);
        n_cmp++;
        if (cyc !== np * 6) begin
            n_bad++;
            $display("FAIL model_latency: got %0d want %0d", cyc, np * 6);
        end
        n_cmp++;
        if (res_passes !== 5'd8) begin
            n_bad++;
            $display("FAIL model_passes: got %0d want 8", res_passes);
        end
        n_cmp++;
        if (res_x !== ex || res_k !== ek) begin
            n_bad++;
            $display("FAIL model_result: got x=%h k=%h want x=%h k=%h", res_x, res_k, ex, ek);
        end
        err = real'(int'(res_x)) - 0.75 * real'(int'(res_k));
        if (err < 0.0) err = -err;
        n_cmp++;
        if (err > 4.0) begin
            n_bad++;
            $display("FAIL model_sqrt: got x-0.75k=%f lsb want <=4", err);
        end
    endtask

    task automatic test_hold(input logic [DW-1:0] ex, input logic [DW-1:0] ek, input int np);
        in_a = 17'h0C000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b1 || res_x !== ex || res_k !== ek || int'(res_passes) !== np
                || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_%0d: got v=%0b x=%h k=%h p=%0d rdy=%0b want 1 %h %h %0d 0",
                         i, res_valid, res_x, res_k, res_passes, in_ready, ex, ek, np);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        in_a = 17'h04000;
        in_valid = 1'b1;
        res_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_handshake: got rdy=%0b v=%0b want 1 1", in_ready, res_valid);
        end
        tick();
        in_valid = 1'b0;
        res_ready = 1'b0;
        n_cmp++;
        if (stg_rot !== 6'd1 || stg_ix !== 17'h08000 || res_valid !== 1'b0 || in_ready !== 1'b0)
        begin
            n_bad++;
            $display("FAIL b2b_issue: got rot=%0d ix=%h v=%0b rdy=%0b want 1 08000 0 0",
                     stg_rot, stg_ix, res_valid, in_ready);
        end
        run_to_done(0, cyc);
        n_cmp++;
        if (cyc !== 24 || res_x !== 17'h08000 || res_passes !== 5'd4) begin
            n_bad++;
            $display("FAIL b2b_result: got cyc=%0d x=%h p=%0d want 24 08000 4",
                     cyc, res_x, res_passes);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        int cyc;
        in_a = 17'h09000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || stg_rot !== '0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_state: got rdy=%0b rot=%0d v=%0b want 1 0 0",
                     in_ready, stg_rot, res_valid);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b0 || stg_rot !== '0 || stg_ix !== '0) begin
                n_bad++;
                $display("FAIL midreset_idle_%0d: got v=%0b rot=%0d ix=%h want 0 0 0",
                         i, res_valid, stg_rot, stg_ix);
            end
        end
        in_a = 17'h04000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_to_done(0, cyc);
        n_cmp++;
        if (cyc !== 24 || res_x !== 17'h08000 || res_k !== 17'h10000 || res_passes !== 5'd4)
        begin
            n_bad++;
            $display("FAIL midreset_newjob: got cyc=%0d x=%h k=%h p=%0d want 24 08000 10000 4",
                     cyc, res_x, res_k, res_passes);
        end
        release_result();
    endtask

    task automatic test_ignore_wait(input logic [DW-1:0] ex, input logic [DW-1:0] ek,
                                    input int np);
        int cyc;
        in_a = 17'h09000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        in_a = 17'h0C000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_ready_%0d: got %0b want 0", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        run_to_done(5, cyc);
        n_cmp++;
        if (cyc !== np * 6 || res_x !== ex || res_k !== ek || int'(res_passes) !== np) begin
            n_bad++;
            $display("FAIL wait_ignore: got cyc=%0d x=%h k=%h p=%0d want %0d %h %h %0d",
                     cyc, res_x, res_k, res_passes, np * 6, ex, ek, np);
        end
        release_result();
    endtask

    initial begin
        logic [DW-1:0] ex, ek;
        int            np;
        test_reset();
        test_first_pass();
        test_model(ex, ek, np);
        test_hold(ex, ek, np);
        test_back_to_back();
        test_reset_mid();
        test_ignore_wait(ex, ek, np);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
